// File: rtl/uart_rx.sv
// Register-mapped 8N1 UART receiver: synchronised serial input, mid-bit sampling
// FSM, small receive FIFO, sticky overrun/frame flags and a programmable divisor.
module uart_rx #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  reg_num,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   bdiv_q, bdiv_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, fe_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovr_q, fe_q;
  logic [15:0]   div_q;

  logic          empty, full, pop, push_ok, ovr_set, clr_wr;
  logic [15:0]   eff_div, half_m1, full_m1;
  logic          unused_wd;

  assign unused_wd = ^wd[31:16];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = re && (reg_num == 3'd0) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign clr_wr  = we && (reg_num == 3'd2);
  assign eff_div = (div_q < 16'd2) ? 16'd2 : div_q;
  assign half_m1 = (bdiv_q >> 1) - 16'd1;
  assign full_m1 = bdiv_q - 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bdiv_q    <= 16'd2;
      idx_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bdiv_q    <= bdiv_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bdiv_d  = bdiv_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Only a true falling edge starts a frame; a line stuck low stays idle.
        if (rx_prev_q && !rx_s_q) begin
          bdiv_d  = eff_div;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == full_m1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == full_m1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) push   = 1'b1;
          else        fe_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (!push_ok && pop) count_q <= count_q - CW'(1);
      // Set has priority over a write-1-to-clear in the same cycle.
      ovr_q <= (ovr_q & ~(clr_wr & wd[2])) | ovr_set;
      fe_q  <= (fe_q & ~(clr_wr & wd[3])) | fe_set;
      if (we && (reg_num == 3'd3)) div_q <= wd[15:0];
    end
  end

  always_comb begin
    rd = '0;
    case (reg_num)
      3'd0: if (!empty) rd[7:0] = mem[rd_ptr_q];
      3'd1: begin
        rd[0]    = !empty;
        rd[1]    = full;
        rd[2]    = ovr_q;
        rd[3]    = fe_q;
        rd[4]    = (state_q != S_IDLE);
        rd[15:8] = 8'(count_q);
      end
      3'd3:    rd[15:0] = div_q;
      default: rd = '0;
    endcase
  end

  assign irq = !empty | ovr_q | fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked against a
// byte-queue model of the receiver with a decoupled RXDATA monitor.
module tb_uart_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  reg_num = 3'd1;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        irq;

  uart_rx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd127)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .we      (we),
    .re      (re),
    .reg_num (reg_num),
    .wd      (wd),
    .rd      (rd),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  model_q[$];
  bit          m_ovr = 1'b0;
  bit          m_fe = 1'b0;
  logic [15:0] m_div = 16'd127;

  function automatic logic [31:0] exp_status();
    return {16'd0, 8'(model_q.size()), 3'd0, 1'b0, m_fe, m_ovr,
            model_q.size() == DEPTH, model_q.size() != 0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: every RXDATA pop strobe is compared with the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (re && reg_num == 3'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rxdata_unexpected: got 0x%08h expected no read", rd);
        end else begin
          check("rxdata", rd, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    re = 1'b0;
    we = 1'b0;
    reg_num = a;
    #2 d = rd;
  endtask

  task automatic check_status(input string name, input logic [31:0] extra = 32'd0);
    logic [31:0] d;
    read_reg(3'd1, d);
    check(name, d, exp_status() | extra);
    check({name, "_irq"}, {31'd0, irq}, {31'd0, (model_q.size() != 0) || m_ovr || m_fe});
  endtask

  task automatic check_div(input string name);
    logic [31:0] d;
    read_reg(3'd3, d);
    check(name, d, {16'd0, m_div});
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] data);
    @(negedge clk);
    reg_num = a;
    wd = data;
    we = 1'b1;
    re = 1'b0;
    @(negedge clk);
    we = 1'b0;
    if (a == 3'd2) begin
      if (data[2]) m_ovr = 1'b0;
      if (data[3]) m_fe = 1'b0;
    end
    if (a == 3'd3) m_div = data[15:0];
  endtask

  task automatic pop_read();
    @(negedge clk);
    if (model_q.size() != 0) exp_q.push_back({24'd0, model_q.pop_front()});
    else                     exp_q.push_back(32'd0);
    reg_num = 3'd0;
    we = 1'b0;
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    reg_num = 3'd1;
  endtask

  // Drives one 8N1 frame at bc clocks per bit and records its outcome in the model.
  task automatic send_byte(input logic [7:0] b, input int bc, input bit stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge clk);
    end
    rx = stop;
    repeat (bc) @(negedge clk);
    if (stop) begin
      if (model_q.size() == DEPTH) m_ovr = 1'b1;
      else                         model_q.push_back(b);
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          dv, bc, npop;

    // Reset state
    gap(3);
    check_status("reset_status");
    check_div("reset_div");
    read_reg(3'd0, d);
    check("reset_rxdata", d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(2);

    // Single byte
    reg_write(3'd3, 32'd8);
    send_byte(8'hA5, 8, 1'b1);
    gap(14);
    check_status("single_status");
    pop_read();
    check_status("single_after_pop");

    // Back-to-back bytes into a full FIFO, then overrun
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 8, 1'b1);
    gap(14);
    check_status("fifo_full_status");
    send_byte(8'h05, 8, 1'b1);
    gap(14);
    check_status("overrun_status");
    for (int i = 0; i < 5; i++) pop_read();
    reg_write(3'd2, 32'h4);
    check_status("overrun_cleared");

    // Framing error with the line held low afterwards
    send_byte(8'h3C, 8, 1'b0);
    gap(40);
    check_status("frame_err_held_low");
    rx = 1'b1;
    gap(14);
    send_byte(8'h7E, 8, 1'b1);
    gap(14);
    check_status("after_frame_err");
    pop_read();
    reg_write(3'd2, 32'h8);
    check_status("frame_err_cleared");

    // Glitch rejection
    @(negedge clk);
    rx = 1'b0;
    gap(2);
    rx = 1'b1;
    check_status("glitch_busy", 32'h10);
    gap(12);
    check_status("glitch_idle");

    // Divisor written mid-frame applies to the next frame only
    fork
      send_byte(8'h5A, 8, 1'b1);
      begin
        gap(30);
        reg_write(3'd3, 32'd3);
      end
    join
    gap(14);
    pop_read();
    check_div("div_three");
    send_byte(8'hC3, 3, 1'b1);
    gap(10);
    pop_read();
    reg_write(3'd3, 32'd1);
    send_byte(8'h99, 2, 1'b1);
    gap(10);
    check_status("div_one_status");
    pop_read();
    check_div("div_one_readback");

    // Reset mid-frame with bytes queued
    reg_write(3'd3, 32'd8);
    send_byte(8'h11, 8, 1'b1);
    send_byte(8'h22, 8, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    gap(30);
    rst_n = 1'b0;
    model_q.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    m_div = 16'd127;
    gap(2);
    rx = 1'b1;
    rst_n = 1'b1;
    gap(4);
    check_status("midframe_reset_status");
    check_div("midframe_reset_div");

    // Pop and push in the same cycle while full
    reg_write(3'd3, 32'd8);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 8, 1'b1);
    gap(14);
    check_status("full_before_simul");
    fork
      send_byte(8'hE7, 8, 1'b1);
      begin
        gap(78);
        pop_read();
      end
    join
    gap(14);
    check_status("simul_pop_push");
    for (int i = 0; i < 4; i++) pop_read();
    check_status("simul_drained");

    // Randomized frames, divisors, pops and clears
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        dv = $urandom_range(0, 12);
        reg_write(3'd3, 32'(dv));
      end
      bc = (m_div < 16'd2) ? 2 : int'(m_div);
      b = 8'($urandom_range(0, 255));
      send_byte(b, bc, $urandom_range(0, 7) != 0);
      rx = 1'b1;
      gap(bc + 6);
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) pop_read();
      if ($urandom_range(0, 5) == 0) reg_write(3'd2, 32'($urandom_range(0, 15)));
      check_status("rand_status");
    end

    // Write-only and unmapped registers read zero
    for (int a = 2; a < 8; a++) begin
      if (a != 3) begin
        read_reg(3'(a), d);
        check("unmapped_read", d, 32'd0);
      end
    end

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL exp_q_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
